// File: rtl/div_func.sv
// Sequential 6-bit signed divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, sign fix-up and special cases in a final cycle.
module div_func (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] z,
  output logic [5:0] rem,
  output logic [5:0] aOut,
  output logic [5:0] bOut,
  output logic       busy,
  output logic       done,
  output logic       overFlow,
  output logic       divZero
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t      state, state_next;
  logic [5:0]  mag_a, mag_b, quo;
  logic [6:0]  prem;
  logic [2:0]  count;
  logic        q_sign, r_sign;
  logic [6:0]  shifted, diff;
  logic        fits;

  assign shifted = {prem[5:0], mag_a[5]};
  assign diff    = shifted - {1'b0, mag_b};
  // A bit shifted out of the partial remainder means it already exceeds any divisor.
  assign fits    = prem[6] | (shifted >= {1'b0, mag_b});
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIV;
      DIV:     if (count == 3'd5) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      aOut     <= '0;
      bOut     <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      quo      <= '0;
      prem     <= '0;
      count    <= '0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      z        <= '0;
      rem      <= '0;
      done     <= 1'b0;
      overFlow <= 1'b0;
      divZero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            aOut   <= a;
            bOut   <= b;
            mag_a  <= a[5] ? -a : a;
            mag_b  <= b[5] ? -b : b;
            q_sign <= a[5] ^ b[5];
            r_sign <= a[5];
            prem   <= '0;
            quo    <= '0;
            count  <= '0;
          end
        end
        DIV: begin
          mag_a <= {mag_a[4:0], 1'b0};
          if (fits) begin
            prem <= diff;
            quo  <= {quo[4:0], 1'b1};
          end else begin
            prem <= shifted;
            quo  <= {quo[4:0], 1'b0};
          end
          count <= count + 3'd1;
        end
        FIX: begin
          done <= 1'b1;
          // Truncating division: remainder carries the dividend's sign.
          if (mag_b == 6'd0) begin
            z        <= 6'b111111;
            rem      <= aOut;
            divZero  <= 1'b1;
            overFlow <= 1'b0;
          end else if (aOut == 6'b100000 && bOut == 6'b111111) begin
            z        <= 6'b100000;
            rem      <= '0;
            divZero  <= 1'b0;
            overFlow <= 1'b1;
          end else begin
            z        <= q_sign ? -quo : quo;
            rem      <= r_sign ? -prem[5:0] : prem[5:0];
            divZero  <= 1'b0;
            overFlow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_func.sv
// Self-checking bench for div_func: table-driven vectors, random vectors
// against a reference model, and hand-written handshake/reset sequences.
module tb_div_func;

  typedef struct packed {
    logic [5:0] z;
    logic [5:0] rem;
    logic       ov;
    logic       dz;
  } res_t;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    res_t       r;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic [5:0] a = '0, b = '0;
  logic [5:0] z, rem, aOut, bOut;
  logic       busy, done, overFlow, divZero;

  int   tests = 0;
  int   failed = 0;
  int   done_count = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  div_func dut (
    .clk(clk), .resetN(resetN), .start(start), .a(a), .b(b),
    .z(z), .rem(rem), .aOut(aOut), .bOut(bOut),
    .busy(busy), .done(done), .overFlow(overFlow), .divZero(divZero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [5:0] x, input logic [5:0] y);
    int   sx, sy, q, r;
    res_t res;
    sx = $signed(x);
    sy = $signed(y);
    res = '0;
    if (sy == 0) begin
      res.z = 6'b111111; res.rem = x; res.dz = 1'b1;
    end else if (sx == -32 && sy == -1) begin
      res.z = 6'b100000; res.rem = '0; res.ov = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      res.z = q[5:0];
      res.rem = r[5:0];
    end
    return res;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin : monitor
    res_t e;
    if (resetN && done) begin
      done_count++;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        e = sb.pop_front();
        check("z", z, e.z);
        check("rem", rem, e.rem);
        check("overFlow", overFlow, e.ov);
        check("divZero", divZero, e.dz);
      end
    end
  end

  task automatic wait_done(input int already);
    int n;
    n = already;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 7);
    check("busy_at_done", busy, 0);
  endtask

  task automatic applyStimulus(input logic [5:0] ta, input logic [5:0] tb_b, input res_t e);
    a = ta; b = tb_b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("aOut", aOut, ta);
    check("bOut", bOut, tb_b);
    a = 6'($urandom);
    b = 6'($urandom);
    wait_done(0);
  endtask

  task automatic checkOutput(input string name);
    check(name, {z, rem, aOut, bOut, busy, done, overFlow, divZero}, 0);
  endtask

  vec_t vecs[11];
  int   dc0;
  logic [5:0] ra, rb;

  initial begin
    vecs[0]  = {6'd27,      6'd5,       6'd5,       6'd2,       1'b0, 1'b0};
    vecs[1]  = {6'b100101,  6'd5,       6'b111011,  6'b111110,  1'b0, 1'b0};
    vecs[2]  = {6'd27,      6'b111011,  6'b111011,  6'b000010,  1'b0, 1'b0};
    vecs[3]  = {6'd7,       6'd0,       6'b111111,  6'b000111,  1'b0, 1'b1};
    vecs[4]  = {6'b100000,  6'b111111,  6'b100000,  6'd0,       1'b1, 1'b0};
    vecs[5]  = {6'b100000,  6'd1,       6'b100000,  6'd0,       1'b0, 1'b0};
    vecs[6]  = {6'd0,       6'd5,       6'd0,       6'd0,       1'b0, 1'b0};
    vecs[7]  = {6'b100001,  6'b111100,  6'd7,       6'b111101,  1'b0, 1'b0};
    vecs[8]  = {6'd31,      6'd1,       6'd31,      6'd0,       1'b0, 1'b0};
    vecs[9]  = {6'b100000,  6'd0,       6'b111111,  6'b100000,  1'b0, 1'b1};
    vecs[10] = {6'd5,       6'd7,       6'd0,       6'd5,       1'b0, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset_state");
    resetN = 1'b1;
    @(negedge clk);

    // Consecutive calls start each new operation during the previous done cycle.
    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].r);

    for (int i = 0; i < 6; i++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      applyStimulus(ra, rb, model(ra, rb));
    end
    repeat (2) @(negedge clk);

    // A start pulse mid-division is ignored.
    dc0 = done_count;
    a = 6'd20; b = 6'd3; start = 1'b1;
    sb.push_back({6'd6, 6'd2, 1'b0, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a = 6'd9; b = 6'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_aOut", aOut, 6'd20);
    check("ignored_bOut", bOut, 6'd3);
    check("ignored_busy", busy, 1);
    wait_done(3);
    repeat (10) @(negedge clk);
    check("single_done", done_count - dc0, 1);

    // Reset in the middle of an operation.
    a = 6'd10; b = 6'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetN = 1'b0;
    #1 checkOutput("async_reset");
    dc0 = done_count;
    @(negedge clk);
    resetN = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", done_count - dc0, 0);
    check("idle_after_reset", busy, 0);

    applyStimulus(6'd31, 6'd31, {6'd1, 6'd0, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
